// File: rtl/capture_checker_pkg.sv
// Shared types and constants for capture_checker: FSM state encoding, drain
// length and the pass-threshold rule.
package capture_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_COMPARE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int unsigned DRAIN_CYCLES = 3;

  // Minimum match count for a pass: exhaustive sweep plus one for combinational
  // logic, more compares than capture bits for sequential logic.
  function automatic int unsigned pass_threshold(input int unsigned seq_logic,
                                                 input int unsigned capture_width);
    if (seq_logic != 0) begin
      return capture_width + 1;
    end
    return (32'd1 << capture_width) + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes the next-state
// value so a caller can act on the count including the current increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_next_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/capture_checker.sv
// Capture-side compare checker: windows the compare on the sweep-end flag,
// counts matches/mismatches and latches a sticky verdict. Optional first-failure
// capture ports are enabled by defining CAPTURE_CHECKER_FIRST_FAIL_EN.
module capture_checker
  import capture_checker_pkg::*;
#(
  parameter int STIMU_WIDTH   = 1,
  parameter int CAPTURE_WIDTH = 1,
  parameter int SEQ_LOGIC     = 0,
  parameter int INIT_ROUND    = 0,
  parameter int TO_CYCLES     = 300,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [STIMU_WIDTH:0]     stimu,
  input  logic [CAPTURE_WIDTH-1:0] capture_ref,
  input  logic [CAPTURE_WIDTH-1:0] capture_duv,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout
`ifdef CAPTURE_CHECKER_FIRST_FAIL_EN
  ,
  output logic                     first_fail_valid,
  output logic [STIMU_WIDTH:0]     first_fail_stimu,
  output logic [CAPTURE_WIDTH-1:0] first_fail_ref,
  output logic [CAPTURE_WIDTH-1:0] first_fail_duv
`endif
);

  localparam int TO_W = $clog2(TO_CYCLES + 1);
  localparam int unsigned THR_INT = pass_threshold(SEQ_LOGIC, CAPTURE_WIDTH);
  localparam logic [CNT_W:0] PASS_THR = THR_INT[CNT_W:0];

  state_t          state_q, state_d;
  logic            flag_q;
  logic [TO_W-1:0] to_q, to_d;
  logic [1:0]      drain_q, drain_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;

  logic             flag_rise;
  logic             start_ok;
  logic             active;
  logic             to_expire;
  logic             match_en;
  logic             mismatch_en;
  logic             verdict;
  logic             finish;
  logic [CNT_W-1:0] match_next;
  logic [CNT_W-1:0] mismatch_next;

  assign flag_rise = stimu[STIMU_WIDTH] & ~flag_q;
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign active    = (state_q == ST_ARM) || (state_q == ST_COMPARE) || (state_q == ST_DRAIN);
  assign to_expire = active && (to_q <= TO_W'(1));

  // An X/Z comparison falls into the else branch and is scored as a mismatch.
  always_comb begin
    match_en    = 1'b0;
    mismatch_en = 1'b0;
    if ((state_q == ST_COMPARE) || (state_q == ST_DRAIN)) begin
      if (capture_ref == capture_duv) begin
        match_en = 1'b1;
      end else begin
        mismatch_en = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (start_ok),
    .en_i         (match_en),
    .count_o      (match_cnt),
    .count_next_o (match_next)
  );

  sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (start_ok),
    .en_i         (mismatch_en),
    .count_o      (mismatch_cnt),
    .count_next_o (mismatch_next)
  );

  // Verdict uses the post-edge counts so the final compare is included.
  assign verdict = ({1'b0, match_next} >= PASS_THR) && (mismatch_next == '0);

  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    drain_d   = drain_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = (INIT_ROUND != 0) ? ST_ARM : ST_COMPARE;
          to_d      = TO_W'(TO_CYCLES);
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_ARM: begin
        to_d = to_q - TO_W'(1);
        if (to_expire) begin
          finish = 1'b1;
        end else if (flag_rise) begin
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        to_d = to_q - TO_W'(1);
        if (to_expire) begin
          finish = 1'b1;
        end else if (flag_rise) begin
          state_d = ST_DRAIN;
          drain_d = 2'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        to_d = to_q - TO_W'(1);
        if (to_expire || (drain_q == 2'd1)) begin
          finish = 1'b1;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      state_d   = ST_DONE;
      done_d    = 1'b1;
      pass_d    = verdict;
      timeout_d = to_expire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      flag_q    <= 1'b0;
      to_q      <= '0;
      drain_q   <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flag_q    <= stimu[STIMU_WIDTH];
      to_q      <= to_d;
      drain_q   <= drain_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = timeout_q;

`ifdef CAPTURE_CHECKER_FIRST_FAIL_EN
  logic                     ff_valid_q;
  logic [STIMU_WIDTH:0]     ff_stimu_q;
  logic [CAPTURE_WIDTH-1:0] ff_ref_q;
  logic [CAPTURE_WIDTH-1:0] ff_duv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid_q <= 1'b0;
      ff_stimu_q <= '0;
      ff_ref_q   <= '0;
      ff_duv_q   <= '0;
    end else if (start_ok) begin
      ff_valid_q <= 1'b0;
      ff_stimu_q <= '0;
      ff_ref_q   <= '0;
      ff_duv_q   <= '0;
    end else if (mismatch_en && !ff_valid_q) begin
      ff_valid_q <= 1'b1;
      ff_stimu_q <= stimu;
      ff_ref_q   <= capture_ref;
      ff_duv_q   <= capture_duv;
    end
  end

  assign first_fail_valid = ff_valid_q;
  assign first_fail_stimu = ff_stimu_q;
  assign first_fail_ref   = ff_ref_q;
  assign first_fail_duv   = ff_duv_q;
`else
  // Stimulus data bits are only consumed by the first-failure capture.
  logic unused_stimu_data;
  assign unused_stimu_data = ^stimu[STIMU_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_capture_checker.sv
// Directed bench for capture_checker: three instances cover the base setup,
// INIT_ROUND=1 and a 4-bit counter width.
module tb_capture_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [2:0] stimu;
  logic       cref;
  logic       cduv;

  logic [15:0] m0, x0, m1, x1;
  logic [3:0]  m2, x2;
  logic        d0, p0, t0, d1, p1, t1, d2, p2, t2;
`ifdef CAPTURE_CHECKER_FIRST_FAIL_EN
  logic       ffv0, ffv1, ffv2;
  logic [2:0] ffs0, ffs1, ffs2;
  logic       ffr0, ffr1, ffr2, ffd0, ffd1, ffd2;
`endif

  int total = 0;
  int bad   = 0;

  capture_checker #(.STIMU_WIDTH(2), .CAPTURE_WIDTH(1), .SEQ_LOGIC(0), .INIT_ROUND(0),
                    .TO_CYCLES(20), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stimu(stimu),
    .capture_ref(cref), .capture_duv(cduv),
    .match_cnt(m0), .mismatch_cnt(x0), .done(d0), .pass(p0), .timeout(t0)
`ifdef CAPTURE_CHECKER_FIRST_FAIL_EN
    , .first_fail_valid(ffv0), .first_fail_stimu(ffs0), .first_fail_ref(ffr0), .first_fail_duv(ffd0)
`endif
  );

  capture_checker #(.STIMU_WIDTH(2), .CAPTURE_WIDTH(1), .SEQ_LOGIC(0), .INIT_ROUND(1),
                    .TO_CYCLES(100), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stimu(stimu),
    .capture_ref(cref), .capture_duv(cduv),
    .match_cnt(m1), .mismatch_cnt(x1), .done(d1), .pass(p1), .timeout(t1)
`ifdef CAPTURE_CHECKER_FIRST_FAIL_EN
    , .first_fail_valid(ffv1), .first_fail_stimu(ffs1), .first_fail_ref(ffr1), .first_fail_duv(ffd1)
`endif
  );

  capture_checker #(.STIMU_WIDTH(2), .CAPTURE_WIDTH(1), .SEQ_LOGIC(0), .INIT_ROUND(0),
                    .TO_CYCLES(100), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stimu(stimu),
    .capture_ref(cref), .capture_duv(cduv),
    .match_cnt(m2), .mismatch_cnt(x2), .done(d2), .pass(p2), .timeout(t2)
`ifdef CAPTURE_CHECKER_FIRST_FAIL_EN
    , .first_fail_valid(ffv2), .first_fail_stimu(ffs2), .first_fail_ref(ffr2), .first_fail_duv(ffd2)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    start = 1'b0;
    stimu = '0;
    cref  = 1'b0;
    cduv  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Drives edges e0..e1 of a sweep: start at edge 0, flag high at edge fa
  // (single pulse) and from edge fb onward, duv inverted at edge inv.
  task automatic drive(input int e0, input int e1, input int fa, input int fb, input int inv);
    for (int e = e0; e <= e1; e++) begin
      logic f;
      f     = (e == fa) || ((e >= fb) && (e > 0));
      start = (e == 0);
      stimu = {f, 2'(e)};
      cref  = e[0];
      cduv  = (e == inv) ? ~e[0] : e[0];
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    do_reset();
    total++; if (m0 !== 16'd0) begin $display("FAIL reset_match got=%0d want=0", m0); bad++; end
    total++; if (x0 !== 16'd0) begin $display("FAIL reset_mismatch got=%0d want=0", x0); bad++; end
    total++; if ({d0, p0, t0} !== 3'b000) begin $display("FAIL reset_flags got=%b want=000", {d0, p0, t0}); bad++; end
`ifdef CAPTURE_CHECKER_FIRST_FAIL_EN
    total++; if (ffv0 !== 1'b0) begin $display("FAIL reset_ff_valid got=%b want=0", ffv0); bad++; end
`endif
    $display("test_reset: m=%0d x=%0d done=%b pass=%b to=%b", m0, x0, d0, p0, t0);
  endtask

  task automatic test_basic_sweep;
    do_reset();
    drive(0, 7, -1, 5, -1);
    total++; if (d0 !== 1'b0) begin $display("FAIL sweep_done_early got=%b want=0", d0); bad++; end
    total++; if (m0 !== 16'd7) begin $display("FAIL sweep_match_e7 got=%0d want=7", m0); bad++; end
    drive(8, 8, -1, 5, -1);
    total++; if (m0 !== 16'd8) begin $display("FAIL sweep_match got=%0d want=8", m0); bad++; end
    total++; if (x0 !== 16'd0) begin $display("FAIL sweep_mismatch got=%0d want=0", x0); bad++; end
    total++; if ({d0, p0, t0} !== 3'b110) begin $display("FAIL sweep_verdict got=%b want=110", {d0, p0, t0}); bad++; end
    drive(9, 11, -1, 5, -1);
    total++; if ({m0, d0, p0} !== {16'd8, 2'b11}) begin $display("FAIL sweep_hold got=%0d/%b%b want=8/11", m0, d0, p0); bad++; end
    $display("test_basic_sweep: m=%0d x=%0d done=%b pass=%b", m0, x0, d0, p0);
  endtask

  task automatic test_back_to_back;
    drive(0, 0, -1, 5, -1);
    total++; if ({m0, d0, p0} !== {16'd0, 2'b00}) begin $display("FAIL rearm_clear got=%0d/%b%b want=0/00", m0, d0, p0); bad++; end
    drive(1, 8, -1, 5, -1);
    total++; if ({m0, x0} !== {16'd8, 16'd0}) begin $display("FAIL rearm_counts got=%0d/%0d want=8/0", m0, x0); bad++; end
    total++; if ({d0, p0} !== 2'b11) begin $display("FAIL rearm_verdict got=%b want=11", {d0, p0}); bad++; end
    $display("test_back_to_back: m=%0d x=%0d done=%b pass=%b", m0, x0, d0, p0);
  endtask

  task automatic test_mismatch;
    do_reset();
    drive(0, 8, -1, 5, 3);
    total++; if ({m0, x0} !== {16'd7, 16'd1}) begin $display("FAIL mis_counts got=%0d/%0d want=7/1", m0, x0); bad++; end
    total++; if ({d0, p0, t0} !== 3'b100) begin $display("FAIL mis_verdict got=%b want=100", {d0, p0, t0}); bad++; end
`ifdef CAPTURE_CHECKER_FIRST_FAIL_EN
    total++; if ({ffv0, ffs0, ffr0, ffd0} !== 6'b1_011_1_0) begin
      $display("FAIL mis_first_fail got=%b want=101110", {ffv0, ffs0, ffr0, ffd0}); bad++; end
`endif
    $display("test_mismatch: m=%0d x=%0d done=%b pass=%b", m0, x0, d0, p0);
  endtask

  task automatic test_init_round;
    do_reset();
    drive(0, 3, 3, 8, -1);
    total++; if (m1 !== 16'd0) begin $display("FAIL init_arm_count got=%0d want=0", m1); bad++; end
    drive(4, 10, 3, 8, -1);
    total++; if ({m1, d1} !== {16'd7, 1'b0}) begin $display("FAIL init_mid got=%0d/%b want=7/0", m1, d1); bad++; end
    drive(11, 11, 3, 8, -1);
    total++; if ({m1, x1} !== {16'd8, 16'd0}) begin $display("FAIL init_counts got=%0d/%0d want=8/0", m1, x1); bad++; end
    total++; if ({d1, p1, t1} !== 3'b110) begin $display("FAIL init_verdict got=%b want=110", {d1, p1, t1}); bad++; end
    $display("test_init_round: m=%0d x=%0d done=%b pass=%b", m1, x1, d1, p1);
  endtask

  task automatic test_timeout;
    do_reset();
    drive(0, 19, -1, 1000, -1);
    total++; if ({d0, m0} !== {1'b0, 16'd19}) begin $display("FAIL to_e19 got=%b/%0d want=0/19", d0, m0); bad++; end
    drive(20, 20, -1, 1000, -1);
    total++; if ({d0, t0, p0} !== 3'b111) begin $display("FAIL to_verdict got=%b want=111", {d0, t0, p0}); bad++; end
    total++; if (m0 !== 16'd20) begin $display("FAIL to_match got=%0d want=20", m0); bad++; end
    drive(0, 20, -1, 20, -1);
    total++; if ({d0, t0} !== 2'b11) begin $display("FAIL to_vs_flag got=%b want=11", {d0, t0}); bad++; end
    $display("test_timeout: m=%0d done=%b to=%b pass=%b", m0, d0, t0, p0);
  endtask

  task automatic test_saturate;
    do_reset();
    drive(0, 15, -1, 18, -1);
    total++; if (m2 !== 4'd15) begin $display("FAIL sat_reach got=%0d want=15", m2); bad++; end
    drive(16, 17, -1, 18, -1);
    total++; if ({m2, d2} !== {4'd15, 1'b0}) begin $display("FAIL sat_hold got=%0d/%b want=15/0", m2, d2); bad++; end
    drive(18, 21, -1, 18, -1);
    total++; if ({m2, x2, d2, p2} !== {4'd15, 4'd0, 2'b11}) begin
      $display("FAIL sat_final got=%0d/%0d/%b%b want=15/0/11", m2, x2, d2, p2); bad++; end
    $display("test_saturate: m=%0d x=%0d done=%b pass=%b", m2, x2, d2, p2);
  endtask

  task automatic test_reset_drain;
    do_reset();
    drive(0, 6, -1, 5, -1);
    total++; if (m0 !== 16'd6) begin $display("FAIL rstdrain_pre got=%0d want=6", m0); bad++; end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({m0, x0, d0, p0, t0} !== 35'd0) begin
      $display("FAIL rstdrain_clear got=%0d/%0d/%b%b%b want=0/0/000", m0, x0, d0, p0, t0); bad++; end
    tick();
    rst_n = 1'b1;
    drive(0, 8, -1, 5, -1);
    total++; if ({m0, x0, d0, p0} !== {16'd8, 16'd0, 2'b11}) begin
      $display("FAIL rstdrain_rerun got=%0d/%0d/%b%b want=8/0/11", m0, x0, d0, p0); bad++; end
    $display("test_reset_drain: m=%0d x=%0d done=%b pass=%b", m0, x0, d0, p0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stimu = '0;
    cref  = 1'b0;
    cduv  = 1'b0;
    test_reset();
    test_basic_sweep();
    test_back_to_back();
    test_mismatch();
    test_init_round();
    test_timeout();
    test_saturate();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
